// File: rtl/sram_master.sv
// ============================================================================
//  Module      : sram_master
//  Description : Single-outstanding bridge from a core load/store request
//                port to a 32-bit synchronous SRAM with active-low byte lane
//                enables. Checks alignment, steers and replicates store
//                data onto the byte lanes, and right-justifies load data.
//
//  Ports
//    clk, rst         : clock, synchronous active-high reset
//    req_*            : core request (valid/ready handshake, write, size,
//                       byte address, right-justified store data)
//    resp_*           : one-cycle completion pulse with load data and error
//    sram_*           : registered SRAM strobes/address/data, plus the
//                       SRAM's read data and its registered completion
//
//  Parameters
//    TIMEOUT_CYCLES   : ACCESS cycles allowed before the access is aborted
//                       (meaningful only when SRAM_MASTER_TIMEOUT_EN is set)
//
//  Build options
//    SRAM_MASTER_TIMEOUT_EN : when defined, an access that sees no
//                       sram_ready for TIMEOUT_CYCLES cycles completes with
//                       resp_err=1. When undefined, ACCESS waits forever.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    // core request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    // core response
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // SRAM
    output logic        sram_cs_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_byte_en_n,
    output logic [12:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    // ------------------------------------------------------------------
    // Elaboration-time sanity check on the parameter
    // ------------------------------------------------------------------
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sram_master: TIMEOUT_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;

    // Request attributes kept for the duration of the access; only the low
    // address bits are needed after acceptance (the word address already
    // lives in sram_addr).
    logic        r_write;
    logic [1:0]  r_size;
    logic [1:0]  r_addr_lo;

    logic        w_accept;
    logic        w_illegal;
    logic [3:0]  w_be_n;
    logic [31:0] w_wdata_lanes;
    logic        w_timeout;

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Request decode: legality, lane enables and lane-replicated data
    // ------------------------------------------------------------------
    always_comb begin
        w_illegal     = 1'b0;
        w_be_n        = 4'hF;
        w_wdata_lanes = 32'h0;
        case (req_size)
            c_SIZE_BYTE: begin
                w_be_n        = ~(4'b0001 << req_addr[1:0]);
                w_wdata_lanes = {4{req_wdata[7:0]}};
            end
            c_SIZE_HALF: begin
                w_illegal     = req_addr[0];
                w_be_n        = req_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata_lanes = {2{req_wdata[15:0]}};
            end
            c_SIZE_WORD: begin
                w_illegal     = |req_addr[1:0];
                w_be_n        = 4'b0000;
                w_wdata_lanes = req_wdata;
            end
            default: begin
                w_illegal     = 1'b1;
            end
        endcase
    end

    // Pull the addressed byte/halfword down to bit 0, zero-extended.
    function automatic logic [31:0] f_extract(
        input logic [1:0]  size,
        input logic [1:0]  lo,
        input logic [31:0] data
    );
        logic [31:0] v;
        v = 32'h0;
        case (size)
            c_SIZE_BYTE: begin
                case (lo)
                    2'd0:    v = {24'h0, data[7:0]};
                    2'd1:    v = {24'h0, data[15:8]};
                    2'd2:    v = {24'h0, data[23:16]};
                    default: v = {24'h0, data[31:24]};
                endcase
            end
            c_SIZE_HALF: v = lo[1] ? {16'h0, data[31:16]} : {16'h0, data[15:0]};
            default:     v = data;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Optional ACCESS watchdog
    // ------------------------------------------------------------------
`ifdef SRAM_MASTER_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    // Counts completed ACCESS cycles that saw no sram_ready. When the
    // current cycle is the last allowed one, the access is abandoned.
    logic [c_TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == S_ACCESS) && !sram_ready && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ACCESS && !sram_ready && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                // sram_ready is only honoured here; elsewhere it is ignored.
                if (sram_ready || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered SRAM strobes and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_cs_n      <= 1'b1;
            sram_we_n      <= 1'b1;
            sram_byte_en_n <= 4'hF;
            sram_addr      <= 13'h0;
            sram_wdata     <= 32'h0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_addr_lo      <= 2'b00;
        end else begin
            // Response fields are only non-zero during the RESP cycle.
            resp_valid <= (w_state_nxt == S_RESP);
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write   <= req_write;
                        r_size    <= req_size;
                        r_addr_lo <= req_addr[1:0];
                        if (w_illegal) begin
                            // Rejected without touching the SRAM.
                            resp_err <= 1'b1;
                        end else begin
                            sram_cs_n      <= 1'b0;
                            sram_we_n      <= ~req_write;
                            sram_byte_en_n <= w_be_n;
                            sram_addr      <= req_addr[14:2];
                            sram_wdata     <= w_wdata_lanes;
                        end
                    end
                end
                S_ACCESS: begin
                    if (sram_ready || w_timeout) begin
                        sram_cs_n      <= 1'b1;
                        sram_we_n      <= 1'b1;
                        sram_byte_en_n <= 4'hF;
                        if (sram_ready) begin
                            if (!r_write) begin
                                resp_rdata <= f_extract(r_size, r_addr_lo, sram_rdata);
                            end
                        end else begin
                            resp_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
